// File: rtl/pl_hazard_ctrl_mc_pkg.sv
// Shared encodings for the multi-cycle pipeline hazard controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pl_hazard_pkg;

    // Operand forwarding mux selects.
    localparam logic [1:0] FWD_E = 2'b00;  // value read in the E stage register
    localparam logic [1:0] FWD_W = 2'b01;  // ResultW from writeback
    localparam logic [1:0] FWD_M = 2'b10;  // ALUResultM from memory stage

    // Multi-cycle execute latency FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pl_hazard_ctrl_mc_md_latency_fsm.sv
// Latency FSM holding a multi-cycle (mul/div) op in Execute for L-1 cycles.
// Latency: stall request is combinational; op advances on its L-th cycle.
// Backpressure: none accepted; raises md_stall_o to freeze F/D/E and bubble M.
module md_latency_fsm
    import pl_hazard_pkg::*;
#(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start_i,
    input  logic [LAT_W-1:0] md_lat_i,
    output logic             md_busy_o,
    output logic             md_done_o,
    output logic             md_stall_o
);

    md_state_e        state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_eff;

    // A latency of zero behaves exactly like a single-cycle op.
    assign lat_eff = (md_lat_i == '0) ? LAT_W'(1) : md_lat_i;

    // State and remaining-stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the start cycle is itself a stall, so BUSY counts L-2 more.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start_i && (lat_eff > LAT_W'(1))) begin
                    state_d = BUSY;
                    cnt_d   = lat_eff - LAT_W'(2);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    // Release cycle: md_start_i still belongs to the held op.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs, forced quiet while reset is held low.
    always_comb begin
        md_busy_o  = 1'b0;
        md_done_o  = 1'b0;
        md_stall_o = 1'b0;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (md_start_i) begin
                        if (lat_eff > LAT_W'(1)) md_stall_o = 1'b1;
                        else                     md_done_o  = 1'b1;
                    end
                end
                BUSY: begin
                    md_busy_o = 1'b1;
                    if (cnt_q != '0) md_stall_o = 1'b1;
                    else             md_done_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pl_hazard_ctrl_mc.sv
// Hazard control for the 5-stage RV32 core: forwarding, load-use, redirect, mul/div hold.
// Latency: all stall/flush/forward outputs are combinational on the current inputs.
// Backpressure: multi-cycle hold > redirect > load-use; redirect during a hold is deferred.
module pl_hazard_ctrl_mc
    import pl_hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int LAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic [REG_W-1:0] rs1E,
    input  logic [REG_W-1:0] rs2E,
    input  logic [REG_W-1:0] rdE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             loadE,
    input  logic             redirectE,
    input  logic             md_start_E,
    input  logic [LAT_W-1:0] md_lat,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             md_stall;
    logic             luse;
    logic             redir_flush;
    logic             redir_pend_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    md_latency_fsm #(
        .LAT_W (LAT_W)
    ) u_md_fsm (
        .clk        (clk),
        .reset      (reset),
        .md_start_i (md_start_E),
        .md_lat_i   (md_lat),
        .md_busy_o  (md_busy),
        .md_done_o  (md_done),
        .md_stall_o (md_stall)
    );

    // Load-use: a multi-cycle op in E wins over the (illegal) load flag.
    assign luse = loadE && RegWriteE && (rdE != '0) &&
                  ((rdE == rs1D) || (rdE == rs2D)) && !md_start_E;

    // A redirect seen while the op was held fires on the release cycle.
    assign redir_flush = redirectE || (md_done && redir_pend_q);

    // RAW forwarding on the E sources; M is younger so it beats W.
    always_comb begin
        fwdA = FWD_E;
        fwdB = FWD_E;
        if (reset) begin
            if (RegWriteM && (rdM != '0) && (rdM == rs1E))      fwdA = FWD_M;
            else if (RegWriteW && (rdW != '0) && (rdW == rs1E)) fwdA = FWD_W;
            if (RegWriteM && (rdM != '0) && (rdM == rs2E))      fwdB = FWD_M;
            else if (RegWriteW && (rdW != '0) && (rdW == rs2E)) fwdB = FWD_W;
        end
    end

    // Stage stall/flush enables in priority order.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (reset) begin
            if (md_stall) begin
                // Held op must survive, so E is frozen rather than flushed.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (redir_flush) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (luse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Remember a redirect raised by the held op until it leaves E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redir_pend_q <= 1'b0;
        end else if (md_stall && redirectE) begin
            redir_pend_q <= 1'b1;
        end else if (md_done) begin
            redir_pend_q <= 1'b0;
        end
    end

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((FlushD || FlushE) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pl_hazard_ctrl_mc.sv
// Self-checking bench for pl_hazard_ctrl_mc: directed scenarios plus a randomized run.
// Latency: inputs change 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: n/a.
module tb_pl_hazard_ctrl_mc;

    localparam int REG_W = 5;
    localparam int LAT_W = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             loadE, redirectE, md_start_E;
    logic [LAT_W-1:0] md_lat;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]       fwdA, fwdB;
    logic             md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: age of the op in E (0 = none), its latency,
    // pending deferred redirect, and the two counters as plain integers.
    int m_age = 0;
    int m_opL = 0;
    bit m_pend = 1'b0;
    int m_scnt = 0;
    int m_fcnt = 0;
    int m_L;
    logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_busy, e_done, e_mdst;
    logic [1:0] e_fa, e_fb;

    pl_hazard_ctrl_mc #(
        .REG_W (REG_W),
        .LAT_W (LAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .rdM        (rdM),
        .rdW        (rdW),
        .RegWriteE  (RegWriteE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .loadE      (loadE),
        .redirectE  (redirectE),
        .md_start_E (md_start_E),
        .md_lat     (md_lat),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        loadE = 0; redirectE = 0; md_start_E = 0; md_lat = '0;
    endtask

    // Expected outputs for the current cycle from the behavioural rules.
    task automatic model_eval();
        logic luse, flush;
        e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0;
        e_busy = 0; e_done = 0; e_mdst = 0; e_fa = 2'b00; e_fb = 2'b00;
        m_L = (md_lat == 0) ? 1 : int'(md_lat);
        if (reset) begin
            if (m_age > 0) begin
                e_busy = 1;
                e_mdst = (m_age < m_opL - 1);
                e_done = (m_age == m_opL - 1);
            end else if (md_start_E) begin
                if (m_L > 1) e_mdst = 1;
                else         e_done = 1;
            end
            luse  = loadE && RegWriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D) && !md_start_E;
            flush = redirectE || (e_done && m_pend);
            if (e_mdst) begin
                e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
            end else if (flush) begin
                e_fd = 1; e_fe = 1;
            end else if (luse) begin
                e_sf = 1; e_sd = 1; e_fe = 1;
            end
            if (RegWriteM && rdM != 0 && rdM == rs1E)      e_fa = 2'b10;
            else if (RegWriteW && rdW != 0 && rdW == rs1E) e_fa = 2'b01;
            if (RegWriteM && rdM != 0 && rdM == rs2E)      e_fb = 2'b10;
            else if (RegWriteW && rdW != 0 && rdW == rs2E) e_fb = 2'b01;
        end
    endtask

    // Advance the model across a rising edge using this cycle's expectations.
    task automatic model_update();
        if (!reset) begin
            m_age = 0; m_opL = 0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (m_age > 0)                      m_age = e_done ? 0 : m_age + 1;
            else if (md_start_E && m_L > 1) begin m_opL = m_L; m_age = 1; end
            if (e_mdst && redirectE) m_pend = 1;
            else if (e_done)         m_pend = 0;
            if (e_sf && m_scnt < CMAX)           m_scnt++;
            if ((e_fd || e_fe) && m_fcnt < CMAX) m_fcnt++;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({StallF, StallD, StallE, FlushD, FlushE, FlushM, md_busy, md_done} !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 00000000",
                {StallF, StallD, StallE, FlushD, FlushE, FlushM, md_busy, md_done});
        end
        n_cmp++;
        if ({fwdA, fwdB, stall_cnt, flush_cnt} !== 12'h000) begin
            n_bad++; $display("FAIL reset_fwd_cnt: got %h required 000", {fwdA, fwdB, stall_cnt, flush_cnt});
        end
        @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_forwarding();
        rs1E = 5; rdM = 5; RegWriteM = 1; rdW = 5; RegWriteW = 1;
        #1; n_cmp++;
        if (fwdA !== 2'b10) begin n_bad++; $display("FAIL fwd_m_prio: got %b required 10", fwdA); end
        RegWriteM = 0;
        #1; n_cmp++;
        if (fwdA !== 2'b01) begin n_bad++; $display("FAIL fwd_w: got %b required 01", fwdA); end
        rs1E = 0; rdM = 0; rdW = 0; RegWriteM = 1;
        #1; n_cmp++;
        if (fwdA !== 2'b00) begin n_bad++; $display("FAIL fwd_x0: got %b required 00", fwdA); end
        rs2E = 9; rdW = 9; rdM = 9; RegWriteM = 0; RegWriteW = 1;
        #1; n_cmp++;
        if (fwdB !== 2'b01 || fwdA !== 2'b00) begin
            n_bad++; $display("FAIL fwdB_w: got A=%b B=%b required A=00 B=01", fwdA, fwdB);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        loadE = 1; RegWriteE = 1; rdE = 7; rs2D = 7;
        #1; n_cmp++;
        if ({StallF, StallD, FlushE, StallE, FlushD} !== 5'b11100) begin
            n_bad++; $display("FAIL load_use: got SF,SD,FE,SE,FD=%b required 11100",
                {StallF, StallD, FlushE, StallE, FlushD});
        end
        tick();
        loadE = 0;
        #1; n_cmp++;
        if (StallF !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %b required 0", StallF); end
        loadE = 1; redirectE = 1;
        #1; n_cmp++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            n_bad++; $display("FAIL redirect_over_luse: got SF,SD,FD,FE=%b required 0011",
                {StallF, StallD, FlushD, FlushE});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_multicycle();
        md_start_E = 1; md_lat = 4;
        for (int c = 1; c <= 4; c++) begin
            #1; n_cmp++;
            if ({StallF, StallE, FlushM, FlushE, md_busy, md_done} !==
                {c <= 3, c <= 3, c <= 3, 1'b0, c >= 2, c == 4}) begin
                n_bad++; $display("FAIL md_lat4_c%0d: got SF,SE,FM,FE,busy,done=%b required %b", c,
                    {StallF, StallE, FlushM, FlushE, md_busy, md_done},
                    {c <= 3, c <= 3, c <= 3, 1'b0, c >= 2, c == 4});
            end
            tick();
        end
        md_start_E = 0;
        #1; n_cmp++;
        if (md_busy !== 1'b0) begin n_bad++; $display("FAIL md_lat4_idle: got busy=%b required 0", md_busy); end
        tick();
    endtask

    task automatic test_single_cycle();
        for (int lat = 0; lat <= 1; lat++) begin
            md_start_E = 1; md_lat = LAT_W'(lat);
            #1; n_cmp++;
            if ({StallF, StallE, md_done, md_busy} !== 4'b0010) begin
                n_bad++; $display("FAIL md_single_lat%0d: got SF,SE,done,busy=%b required 0010", lat,
                    {StallF, StallE, md_done, md_busy});
            end
            tick();
            md_start_E = 0;
            #1; n_cmp++;
            if ({md_busy, md_done} !== 2'b00) begin
                n_bad++; $display("FAIL md_single_after_lat%0d: got busy,done=%b required 00", lat, {md_busy, md_done});
            end
            tick();
        end
    endtask

    task automatic test_redirect_defer();
        for (int hold = 1; hold >= 0; hold--) begin
            md_start_E = 1; md_lat = 3; redirectE = 1;
            for (int c = 1; c <= 3; c++) begin
                #1; n_cmp++;
                if ({FlushD, FlushE, StallE} !== {c == 3, c == 3, c < 3}) begin
                    n_bad++; $display("FAIL redir_defer_h%0d_c%0d: got FD,FE,SE=%b required %b", hold, c,
                        {FlushD, FlushE, StallE}, {c == 3, c == 3, c < 3});
                end
                tick();
                if (hold == 0) redirectE = 0;
            end
            clear_inputs();
            tick();
        end
    endtask

    task automatic test_reset_busy();
        md_start_E = 1; md_lat = 8;
        tick();
        reset = 0;
        #1; n_cmp++;
        if ({StallF, StallD, StallE, FlushM, md_busy, stall_cnt, flush_cnt} !== '0) begin
            n_bad++; $display("FAIL reset_mid_busy: got SF,SD,SE,FM,busy=%b cnt=%0d/%0d required all 0",
                {StallF, StallD, StallE, FlushM, md_busy}, stall_cnt, flush_cnt);
        end
        md_start_E = 0;
        tick();
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            #1; n_cmp++;
            if ({md_busy, StallF, StallE} !== 3'b000) begin
                n_bad++; $display("FAIL after_reset_idle_c%0d: got busy,SF,SE=%b required 000", c,
                    {md_busy, StallF, StallE});
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        int base;
        base = m_scnt;
        loadE = 1; RegWriteE = 1; rdE = 3; rs1D = 3;
        for (int c = 1; c <= (1 << CNT_W) + 3; c++) begin
            tick();
            if (c == CMAX - 1 - base) begin
                n_cmp++;
                if (stall_cnt !== CNT_W'(CMAX - 1)) begin
                    n_bad++; $display("FAIL stall_cnt_count: got %0d required %0d", stall_cnt, CMAX - 1);
                end
            end
        end
        n_cmp++;
        if (stall_cnt !== CNT_W'(CMAX) || flush_cnt !== CNT_W'(CMAX)) begin
            n_bad++; $display("FAIL cnt_saturate: got stall=%0d flush=%0d required %0d/%0d",
                stall_cnt, flush_cnt, CMAX, CMAX);
        end
        clear_inputs();
        tick();
        n_cmp++;
        if (stall_cnt !== CNT_W'(CMAX)) begin
            n_bad++; $display("FAIL cnt_hold: got %0d required %0d", stall_cnt, CMAX);
        end
    endtask

    task automatic test_random();
        logic [19:0] got_v, exp_v;
        for (int c = 0; c < 400; c++) begin
            rs1D = REG_W'($urandom_range(0, 3)); rs2D = REG_W'($urandom_range(0, 3));
            rs1E = REG_W'($urandom_range(0, 3)); rs2E = REG_W'($urandom_range(0, 3));
            rdE = REG_W'($urandom_range(0, 3)); rdM = REG_W'($urandom_range(0, 3));
            rdW = REG_W'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            redirectE = ($urandom_range(0, 7) == 0);
            md_lat = LAT_W'($urandom_range(0, 6));
            md_start_E = (m_age > 0) ? 1'b1 : ($urandom_range(0, 5) == 0);
            loadE = md_start_E ? 1'b0 : 1'($urandom);
            model_eval();
            #1;
            got_v = {StallF, StallD, StallE, FlushD, FlushE, FlushM, fwdA, fwdB, md_busy, md_done,
                     stall_cnt, flush_cnt};
            exp_v = {e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_fa, e_fb, e_busy, e_done,
                     CNT_W'(m_scnt), CNT_W'(m_fcnt)};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++; $display("FAIL random_c%0d: got %h required %h", c, got_v, exp_v);
            end
            @(posedge clk);
            model_update();
            #1;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_single_cycle();
        test_redirect_defer();
        test_reset_busy();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
